fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding and load-use hazard unit for the multi-lane in-order pipeline.

---
 rtl/fwd_hazard_unit.sv | 164 ++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and load-use hazard unit for a multi-lane in-order pipeline.
//   Keeps a shadow EX/MEM/WB pipeline of destination tags per lane.
//   It produces per-operand bypass selects for the bundle in EX and a
//   load-use stall for the bundle in ID. Register 0 is never forwarded or
//   stalled on.
//
// Ports
//   clk_i          rising-edge clock
//   rst_n_i        synchronous active-low reset
//   id_valid_i     [LANES]        ID lane holds an instruction
//   id_rs_i        [LANES*2*AW]   sources, lane k op j at [(2k+j)*AW +: AW]
//   id_rd_i        [LANES*AW]     destination per lane
//   id_we_i        [LANES]        lane writes id_rd
//   id_load_i      [LANES]        lane is a load (data ready at end of MEM)
//   flush_i        kill the ID bundle, EX captures a bubble
//   stall_o        hold ID/IF, EX captures a bubble
//   fwd_stage_o    [LANES*2*2]    per EX operand: 00 regfile, 10 MEM, 01 WB
//   fwd_lane_o     [LANES*2*LW]   producing lane for a non-00 select, else 0
//   stall_cnt_o    [CNT_W]        stall cycle count (FWD_STALL_CNT_EN only)
//
// Build option
//   FWD_STALL_CNT_EN : adds the wrapping stall-cycle counter, its CNT_W
//                      parameter and the stall_cnt_o port.
module fwd_hazard_unit #(
    parameter int LANES = 2,
    parameter int AW    = 3,
    parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
`ifdef FWD_STALL_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [LANES-1:0]         id_valid_i,
    input  logic [LANES*2*AW-1:0]    id_rs_i,
    input  logic [LANES*AW-1:0]      id_rd_i,
    input  logic [LANES-1:0]         id_we_i,
    input  logic [LANES-1:0]         id_load_i,
    input  logic                     flush_i,
    output logic                     stall_o,
`ifdef FWD_STALL_CNT_EN
    output logic [CNT_W-1:0]         stall_cnt_o,
`endif
    output logic [LANES*2*2-1:0]     fwd_stage_o,
    output logic [LANES*2*LW-1:0]    fwd_lane_o
);

    // Packed views matching the flat port layout: [lane][op]
    logic [LANES-1:0][1:0][AW-1:0] id_rs;
    logic [LANES-1:0][AW-1:0]      id_rd;
    assign id_rs = id_rs_i;
    assign id_rd = id_rd_i;

    // Shadow pipeline. WB never needs ld; only EX needs the sources.
    logic [LANES-1:0]              ex_v_q, ex_we_q, ex_ld_q;
    logic [LANES-1:0]              ex_v_d, ex_we_d, ex_ld_d;
    logic [LANES-1:0][AW-1:0]      ex_rd_q;
    logic [LANES-1:0][1:0][AW-1:0] ex_rs_q;
    logic [LANES-1:0]              mem_v_q, mem_we_q, mem_ld_q;
    logic [LANES-1:0][AW-1:0]      mem_rd_q;
    logic [LANES-1:0]              wb_v_q, wb_we_q;
    logic [LANES-1:0][AW-1:0]      wb_rd_q;

    logic                          ld_hit;
    logic                          capture;

    // Load-use: any live ID source matching a load still in EX.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < 2; j++) begin
                for (int k = 0; k < LANES; k++) begin
                    if (id_valid_i[i] && (id_rs[i][j] != '0) &&
                        ex_v_q[k] && ex_we_q[k] && ex_ld_q[k] &&
                        (ex_rd_q[k] == id_rs[i][j]))
                        ld_hit = 1'b1;
                end
            end
        end
        stall_o = ld_hit & ~flush_i;
    end

    assign capture = ~stall_o & ~flush_i;
    assign ex_v_d  = id_valid_i & {LANES{capture}};
    assign ex_we_d = id_we_i    & {LANES{capture}};
    assign ex_ld_d = id_load_i  & {LANES{capture}};

    // Bypass select. WB is scanned first and MEM afterwards so the younger
    // stage overwrites; ascending lane order lets the highest lane win.
    // A load in MEM has no data yet, so it is skipped.
    logic [LANES-1:0][1:0][1:0]    fstage;
    logic [LANES-1:0][1:0][LW-1:0] flane;

    always_comb begin
        fstage = '0;
        flane  = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (ex_v_q[i] && (ex_rs_q[i][j] != '0)) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (wb_v_q[k] && wb_we_q[k] && (wb_rd_q[k] == ex_rs_q[i][j])) begin
                            fstage[i][j] = 2'b01;
                            flane[i][j]  = LW'(k);
                        end
                    end
                    for (int k = 0; k < LANES; k++) begin
                        if (mem_v_q[k] && mem_we_q[k] && !mem_ld_q[k] &&
                            (mem_rd_q[k] == ex_rs_q[i][j])) begin
                            fstage[i][j] = 2'b10;
                            flane[i][j]  = LW'(k);
                        end
                    end
                end
            end
        end
    end

    assign fwd_stage_o = fstage;
    assign fwd_lane_o  = flane;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ex_v_q   <= '0;
            ex_we_q  <= '0;
            ex_ld_q  <= '0;
            ex_rd_q  <= '0;
            ex_rs_q  <= '0;
            mem_v_q  <= '0;
            mem_we_q <= '0;
            mem_ld_q <= '0;
            mem_rd_q <= '0;
            wb_v_q   <= '0;
            wb_we_q  <= '0;
            wb_rd_q  <= '0;
        end else begin
            ex_v_q   <= ex_v_d;
            ex_we_q  <= ex_we_d;
            ex_ld_q  <= ex_ld_d;
            ex_rd_q  <= id_rd;
            ex_rs_q  <= id_rs;
            mem_v_q  <= ex_v_q;
            mem_we_q <= ex_we_q;
            mem_ld_q <= ex_ld_q;
            mem_rd_q <= ex_rd_q;
            wb_v_q   <= mem_v_q;
            wb_we_q  <= mem_we_q;
            wb_rd_q  <= mem_rd_q;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign cnt_d = stall_o ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign stall_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    typedef struct packed {
        logic [1:0]           v, we, ld;
        logic [1:0][2:0]      rd;
        logic [1:0][1:0][2:0] rs;
    } bundle_t;

    typedef struct {
        logic        rn;
        logic [1:0]  vl, we, ld;
        logic [5:0]  rd;
        logic [11:0] rs;
        logic        fl;
        logic        es;
        logic [7:0]  est;
        logic [3:0]  eln;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  id_valid, id_we, id_load;
    logic [5:0]  id_rd;
    logic [11:0] id_rs;
    logic        flush;
    logic        stall;
    logic [7:0]  fwd_stage;
    logic [3:0]  fwd_lane;
`ifdef FWD_STALL_CNT_EN
    logic [1:0]  stall_cnt;
    logic [1:0]  mcnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference: bundle history by age (0 = EX, 1 = MEM, 2 = WB).
    bundle_t hist[$];

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .LANES(2), .AW(3), .LW(1)
`ifdef FWD_STALL_CNT_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rd_i(id_rd),
        .id_we_i(id_we), .id_load_i(id_load), .flush_i(flush),
        .stall_o(stall),
`ifdef FWD_STALL_CNT_EN
        .stall_cnt_o(stall_cnt),
`endif
        .fwd_stage_o(fwd_stage), .fwd_lane_o(fwd_lane)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_stall(input bundle_t id, input logic fl);
        bundle_t e;
        logic    s;
        e = hist[0];
        s = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 2; k++)
                    if (id.v[i] && id.rs[i][j] != 3'd0 && e.v[k] && e.we[k] && e.ld[k] &&
                        e.rd[k] == id.rs[i][j])
                        s = 1'b1;
        return s && !fl;
    endfunction

    // Search producers youngest-first: MEM then WB, highest lane first.
    function automatic void m_fwd(output logic [7:0] st, output logic [3:0] ln);
        bundle_t ex, p;
        logic    found;
        logic [2:0] r;
        st = '0;
        ln = '0;
        ex = hist[0];
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                r = ex.rs[i][j];
                found = 1'b0;
                if (ex.v[i] && r != 3'd0) begin
                    for (int age = 1; age <= 2; age++) begin
                        for (int k = 1; k >= 0; k--) begin
                            p = hist[age];
                            if (!found && p.v[k] && p.we[k] && !(age == 1 && p.ld[k]) && p.rd[k] == r) begin
                                found = 1'b1;
                                st[(2*i+j)*2 +: 2] = (age == 1) ? 2'b10 : 2'b01;
                                ln[2*i+j] = 1'(k);
                            end
                        end
                    end
                end
            end
        end
    endfunction

    task automatic step(input vec_t v, input bit use_tab);
        bundle_t    idb;
        logic       ms;
        logic [7:0] mst;
        logic [3:0] mln;
        rst_n = v.rn; id_valid = v.vl; id_we = v.we; id_load = v.ld;
        id_rd = v.rd; id_rs = v.rs; flush = v.fl;
        #1;
        idb.v = v.vl; idb.we = v.we; idb.ld = v.ld; idb.rd = v.rd; idb.rs = v.rs;
        ms = m_stall(idb, v.fl);
        m_fwd(mst, mln);
        if (use_tab) begin
            chk("tab_stall", {31'd0, stall}, {31'd0, v.es});
            chk("tab_fwd_stage", {24'd0, fwd_stage}, {24'd0, v.est});
            chk("tab_fwd_lane", {28'd0, fwd_lane}, {28'd0, v.eln});
        end else begin
            chk("rnd_stall", {31'd0, stall}, {31'd0, ms});
            chk("rnd_fwd_stage", {24'd0, fwd_stage}, {24'd0, mst});
            chk("rnd_fwd_lane", {28'd0, fwd_lane}, {28'd0, mln});
        end
`ifdef FWD_STALL_CNT_EN
        chk("stall_cnt", {30'd0, stall_cnt}, {30'd0, mcnt});
`endif
        @(posedge clk);
        if (!v.rn) begin
            hist = '{'0, '0, '0};
`ifdef FWD_STALL_CNT_EN
            mcnt = '0;
`endif
        end else begin
`ifdef FWD_STALL_CNT_EN
            if (ms) mcnt = mcnt + 2'd1;
`endif
            hist.push_front((ms || v.fl) ? bundle_t'('0) : idb);
            void'(hist.pop_back());
        end
        @(negedge clk);
    endtask

    function automatic vec_t row(input logic rn, input logic [1:0] vl, we, ld,
                                 input logic [5:0] rd, input logic [11:0] rs, input logic fl,
                                 input logic es, input logic [7:0] est, input logic [3:0] eln);
        vec_t r;
        r.rn = rn; r.vl = vl; r.we = we; r.ld = ld; r.rd = rd; r.rs = rs; r.fl = fl;
        r.es = es; r.est = est; r.eln = eln;
        return r;
    endfunction

    function automatic logic [11:0] rsv(input int a, b, c, d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic logic [5:0] rdv(input int l0, l1);
        return {3'(l1), 3'(l0)};
    endfunction

    vec_t tab[31];
    vec_t idle;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        idle = row(1, 2'b00, 2'b00, 2'b00, 6'd0, 12'd0, 0, 0, 8'h00, 4'h0);
        // Reset with junk ID traffic
        tab[0]  = row(0, 2'b11, 2'b11, 2'b11, rdv(2,2), rsv(2,2,2,2), 0, 0, 8'h00, 4'h0);
        tab[1]  = tab[0];
        // EX-to-EX: A writes r3 in lane0, B lane1 op0 reads r3
        tab[2]  = row(1, 2'b01, 2'b01, 2'b00, rdv(3,0), rsv(0,0,0,0), 0, 0, 8'h00, 4'h0);
        tab[3]  = row(1, 2'b10, 2'b00, 2'b00, rdv(0,0), rsv(0,0,3,0), 0, 0, 8'h00, 4'h0);
        // P1 lane1 r5, P2 lane0 r5, reader lane0 op1: MEM (lane0) wins over WB
        tab[4]  = row(1, 2'b10, 2'b10, 2'b00, rdv(0,5), rsv(0,0,0,0), 0, 0, 8'h20, 4'h0);
        tab[5]  = row(1, 2'b01, 2'b01, 2'b00, rdv(5,0), rsv(0,0,0,0), 0, 0, 8'h00, 4'h0);
        tab[6]  = row(1, 2'b01, 2'b00, 2'b00, rdv(0,0), rsv(0,5,0,0), 0, 0, 8'h00, 4'h0);
        tab[7]  = idle; tab[7].est = 8'h08;
        tab[8]  = idle;
        // WB-only: lane1 r6, bubble, reader lane0 op0 -> 01 lane1
        tab[9]  = row(1, 2'b10, 2'b10, 2'b00, rdv(0,6), rsv(0,0,0,0), 0, 0, 8'h00, 4'h0);
        tab[10] = idle;
        tab[11] = row(1, 2'b01, 2'b00, 2'b00, rdv(0,0), rsv(6,0,0,0), 0, 0, 8'h00, 4'h0);
        tab[12] = idle; tab[12].est = 8'h01; tab[12].eln = 4'h1;
        // Both lanes write r5 in one bundle -> lane1 selected
        tab[13] = row(1, 2'b11, 2'b11, 2'b00, rdv(5,5), rsv(0,0,0,0), 0, 0, 8'h00, 4'h0);
        tab[14] = row(1, 2'b10, 2'b00, 2'b00, rdv(0,0), rsv(0,0,0,5), 0, 0, 8'h00, 4'h0);
        tab[15] = idle; tab[15].est = 8'h80; tab[15].eln = 4'h8;
        // Load-use: one stall cycle, then WB forward
        tab[16] = row(1, 2'b01, 2'b01, 2'b01, rdv(2,0), rsv(0,0,0,0), 0, 0, 8'h00, 4'h0);
        tab[17] = row(1, 2'b01, 2'b00, 2'b00, rdv(0,0), rsv(2,0,0,0), 0, 1, 8'h00, 4'h0);
        tab[18] = tab[17]; tab[18].es = 0;
        tab[19] = idle; tab[19].est = 8'h01;
        // Zero register load and reader
        tab[20] = row(1, 2'b01, 2'b01, 2'b01, rdv(0,0), rsv(0,0,0,0), 0, 0, 8'h00, 4'h0);
        tab[21] = row(1, 2'b01, 2'b00, 2'b00, rdv(0,0), rsv(0,0,0,0), 0, 0, 8'h00, 4'h0);
        // ALU r4, load r4, flushed reader: a captured reader would see WB lane1
        tab[22] = row(1, 2'b10, 2'b10, 2'b00, rdv(0,4), rsv(0,0,0,0), 0, 0, 8'h00, 4'h0);
        tab[23] = row(1, 2'b01, 2'b01, 2'b01, rdv(4,0), rsv(0,0,0,0), 0, 0, 8'h00, 4'h0);
        tab[24] = row(1, 2'b01, 2'b00, 2'b00, rdv(0,0), rsv(4,0,0,0), 1, 0, 8'h00, 4'h0);
        tab[25] = idle;
        tab[26] = idle;
        // Reset mid-flight drops the producer of r7
        tab[27] = row(1, 2'b01, 2'b01, 2'b00, rdv(7,0), rsv(0,0,0,0), 0, 0, 8'h00, 4'h0);
        tab[28] = row(0, 2'b01, 2'b00, 2'b00, rdv(0,0), rsv(7,0,0,0), 0, 0, 8'h00, 4'h0);
        tab[29] = tab[28]; tab[29].rn = 1;
        tab[30] = idle;

        rst_n = 1'b0; id_valid = 2'b11; id_we = 2'b11; id_load = 2'b11;
        id_rd = 6'h12; id_rs = 12'hA5A; flush = 1'b0;
        hist = '{'0, '0, '0};
`ifdef FWD_STALL_CNT_EN
        mcnt = '0;
`endif
        @(posedge clk);
        @(negedge clk);

        for (int n = 0; n < 31; n++) step(tab[n], 1'b1);

        for (int n = 0; n < 400; n++) begin
            vec_t r;
            r = row(($urandom_range(0, 49) != 0), 2'($urandom), 2'($urandom), 2'($urandom),
                    6'($urandom), 12'($urandom), ($urandom_range(0, 9) == 0), 0, 8'h00, 4'h0);
            step(r, 1'b0);
        end

`ifdef FWD_STALL_CNT_EN
        begin
            logic [1:0] cexp[5];
            vec_t ld_r, use_r;
            cexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            ld_r  = row(1, 2'b01, 2'b01, 2'b01, rdv(2,0), rsv(0,0,0,0), 0, 0, 8'h00, 4'h0);
            use_r = row(1, 2'b01, 2'b00, 2'b00, rdv(0,0), rsv(2,0,0,0), 0, 0, 8'h00, 4'h0);
            step(row(0, 2'b00, 2'b00, 2'b00, 6'd0, 12'd0, 0, 0, 8'h00, 4'h0), 1'b0);
            for (int n = 0; n < 5; n++) begin
                step(ld_r, 1'b0);
                step(use_r, 1'b0);
                step(use_r, 1'b0);
                chk("cnt_seq", {30'd0, stall_cnt}, {30'd0, cexp[n]});
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
